seg7_scan_display: RTL
======================

Name: seg7_scan_display

Overview:
Parametrised multiplexed 7-segment display driver. It converts a binary value to decimal (sequential double-dabble) or hexadecimal digits, optionally blanks leading zeros and flags overflow. It then time-multiplexes NUM_DIGITS digits onto one shared active-low segment bus with one-hot active-low digit enables. It sits between game-state/score logic and the board's 7-segment pins, and replaces per-digit static segment outputs.

Parameters:
NUM_DIGITS, 4, number of displayed digits (>=1)
BIN_WIDTH, 14, width of binary input value
REFRESH_DIV, 20000, clock cycles each digit is enabled per scan step (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset (asserted at 0)
value_i  input  BIN_WIDTH  binary value to display
load_i  input  1  request conversion of value_i; accepted only when busy_o=0
hex_mode_i  input  1  1=hex digits, 0=decimal; sampled with load_i
blank_lz_i  input  1  1=blank leading zeros; sampled with load_i
dp_i  input  NUM_DIGITS  per-digit decimal point, 1=lit; sampled with load_i
busy_o  output  1  conversion in progress
overflow_o  output  1  last committed value did not fit in NUM_DIGITS digits
seg_o  output  7  segments, bit6=a .. bit0=g, active-low
dp_o  output  1  decimal point of the active digit, active-low
an_o  output  NUM_DIGITS  digit enables, one-hot active-low

Behaviour:
- Reset (rst=0, async): FSM=IDLE; busy_o=0; overflow_o=0; display register all-blank; dp register 0; scan index 0; refresh counter 0; seg_o=7'b1111111; dp_o=1; an_o=all ones.
- FSM IDLE -> CONVERT on load_i=1 with hex_mode_i=0. IDLE -> COMMIT on load_i=1 with hex_mode_i=1. CONVERT -> COMMIT after exactly BIN_WIDTH shift cycles. COMMIT -> IDLE.
- busy_o is a registered output, high in CONVERT and COMMIT. Decimal: busy for BIN_WIDTH+1 cycles. Hex: busy for 1 cycle.
- load_i while busy_o=1 is ignored; no queueing.
- The capture cycle latches value_i, hex_mode_i, blank_lz_i and dp_i.
- Decimal conversion: BCD shift register of BCD_DIGITS=(BIN_WIDTH+2)/3 digits. Each cycle, add 3 to every digit >=5, then shift left one bit, injecting the value MSB.
- Decimal overflow: any BCD digit at index >= NUM_DIGITS is nonzero. Hex overflow: any value bit at index >= 4*NUM_DIGITS is set.
- COMMIT writes the display and dp registers and overflow_o in one cycle. The display register changes only in COMMIT, so the scan never shows a partial result.
- On overflow, every digit shows a dash (7'b1111110), dp is still honoured, and overflow_o=1 until the next COMMIT.
- Leading-zero blanking: when enabled and not overflowed, zero digits from index NUM_DIGITS-1 downward are blanked (7'b1111111) until the first nonzero digit. Digit 0 is never blanked.
- Encodings (active-low, abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- Scan: the refresh counter counts 0..REFRESH_DIV-1. On wrap, the scan index increments, going from NUM_DIGITS-1 back to 0.
- Scan outputs are registered each cycle from the current index: an_o=~(1<<idx), seg_o=display[idx], dp_o=~dp[idx]. The first post-reset edge drives digit 0.
- Scanning runs continuously and independently of the FSM.
- Reset asserted mid-conversion aborts the conversion and blanks the display immediately.

Decomposition:
- Package seg7_pkg holds:
  - segment constants SEG_BLANK and SEG_DASH
  - function hex_to_seg(4-bit) -> 7-bit
  - FSM state typedef {IDLE, CONVERT, COMMIT}
- One sub-module, seg7_bin2bcd: the sequential double-dabble shifter. Interface: start, value, done, bcd out.
- Blanking, overflow, commit and scan logic stay in seg7_scan_display.

Test Plan:
All scenarios use NUM_DIGITS=4, BIN_WIDTH=14, REFRESH_DIV=4.
- Reset: rst=0 -> an_o=1111, seg_o=1111111, dp_o=1, busy_o=0, overflow_o=0. Release rst -> an_o=1110, and each digit stays enabled 4 cycles.
- Decimal 1234, blank_lz_i=0, dp_i=0100:
  - busy_o high for 15 cycles.
  - Then digit0=1001100, digit1=0000110, digit2=0010010 with dp_o=0, digit3=1001111.
- Decimal 7 with blank_lz_i=1 -> digits 3..1=1111111, digit0=0001111. Decimal 0 with blank_lz_i=1 -> digit0=0000001, others blank.
- Decimal 12000 -> overflow_o=1, all digits 1111110. Then hex 0x2AF, blank_lz_i=0:
  - busy_o high exactly 1 cycle.
  - Digits 3..0 = 0000001, 0010010, 0001000, 0111000; overflow_o=0.
- Second load_i pulse mid-conversion of 1234 is ignored and 1234 is displayed. rst pulsed low mid-conversion -> busy_o=0 and all digits blank.
- Hex 0x1ABCD with BIN_WIDTH=17 -> overflow_o=1 and dashes.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants, segment encoder and FSM state type for the multiplexed 7-segment driver.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CONVERT = 2'd1;
   localparam logic [1:0] ST_COMMIT  = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      CONVERT = ST_CONVERT,
      COMMIT  = ST_COMMIT
   } state_e;

   // Active-low abcdefg, bit6 = a.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'b0000001;
         4'h1: seg = 7'b1001111;
         4'h2: seg = 7'b0010010;
         4'h3: seg = 7'b0000110;
         4'h4: seg = 7'b1001100;
         4'h5: seg = 7'b0100100;
         4'h6: seg = 7'b0100000;
         4'h7: seg = 7'b0001111;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0000100;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b1100000;
         4'hC: seg = 7'b0110001;
         4'hD: seg = 7'b1000010;
         4'hE: seg = 7'b0110000;
         default: seg = 7'b0111000;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Load-side bus of the 7-segment driver: value/mode capture request plus status back.
interface seg7_scan_display_if #(
   parameter int NUM_DIGITS = 4,
   parameter int BIN_WIDTH  = 14
);
   logic [BIN_WIDTH-1:0]  value_i;
   logic                  load_i;
   logic                  hex_mode_i;
   logic                  blank_lz_i;
   logic [NUM_DIGITS-1:0] dp_i;
   logic                  busy_o;
   logic                  overflow_o;

   modport master (
      output value_i, load_i, hex_mode_i, blank_lz_i, dp_i,
      input  busy_o, overflow_o
   );

   modport slave (
      input  value_i, load_i, hex_mode_i, blank_lz_i, dp_i,
      output busy_o, overflow_o
   );
endinterface

// File: rtl/seg7_bin2bcd.sv
// Sequential double-dabble: one add-3/shift step per cycle, BIN_WIDTH steps after start.
module seg7_bin2bcd #(
   parameter int BIN_WIDTH  = 14,
   parameter int BCD_DIGITS = (BIN_WIDTH + 2) / 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start_i,
   input  logic [BIN_WIDTH-1:0]    value_i,
   output logic                    done_o,
   output logic [4*BCD_DIGITS-1:0] bcd_o
);
   localparam int BCD_W = 4 * BCD_DIGITS;
   localparam int CNT_W = $clog2(BIN_WIDTH + 1);

   logic [BIN_WIDTH-1:0] shift_q, shift_d;
   logic [BCD_W-1:0]     bcd_q, bcd_d, adj;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      shift_d = shift_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      if (start_i) begin
         shift_d = value_i;
         bcd_d   = '0;
         cnt_d   = CNT_W'(BIN_WIDTH);
      end else if (cnt_q != '0) begin
         bcd_d   = {adj[BCD_W-2:0], shift_q[BIN_WIDTH-1]};
         shift_d = shift_q << 1;
         cnt_d   = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
      end
   end

   // High during the final shift, so the caller can move on at the same edge.
   assign done_o = (cnt_q == CNT_W'(1));
   assign bcd_o  = bcd_q;
endmodule

// File: rtl/seg7_scan_display.sv
// Binary-to-digit conversion, blanking/overflow commit and time-multiplexed 7-segment scan.
// state   | meaning
// IDLE    | waiting for load_i; display holds the last committed value
// CONVERT | double-dabble running, BIN_WIDTH cycles
// COMMIT  | display, dp and overflow registers written in one cycle
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int BIN_WIDTH   = 14,
   parameter int REFRESH_DIV = 20000
) (
   input  logic                  clk,
   input  logic                  rst,
   seg7_scan_display_if.slave    bus,
   output logic [6:0]            seg_o,
   output logic                  dp_o,
   output logic [NUM_DIGITS-1:0] an_o
);
   localparam int BCD_DIGITS = (BIN_WIDTH + 2) / 3;
   localparam int BCD_W      = 4 * BCD_DIGITS;
   localparam int DIG_W      = 4 * NUM_DIGITS;
   localparam int HEX_EXT_W  = (BIN_WIDTH > DIG_W) ? BIN_WIDTH : DIG_W;
   localparam int BCD_EXT_W  = (BCD_W > DIG_W) ? BCD_W : DIG_W;
   localparam int REF_W      = $clog2(REFRESH_DIV + 1);
   localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   state_e                     state_q, state_d;
   logic                       busy_q, busy_d;
   logic                       ovf_q, ovf_d, ovf_new;
   logic [BIN_WIDTH-1:0]       value_q, value_d;
   logic                       hex_q, hex_d, blank_q, blank_d;
   logic [NUM_DIGITS-1:0]      dpcap_q, dpcap_d, dpr_q, dpr_d;
   logic [NUM_DIGITS-1:0][6:0] disp_q, disp_d, disp_new;
   logic [REF_W-1:0]           ref_q, ref_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [NUM_DIGITS-1:0]      an_q, an_d;
   logic [6:0]                 seg_q, seg_d;
   logic                       dpo_q, dpo_d;
   logic                       conv_start, conv_done;
   logic [BCD_W-1:0]           bcd;
   logic [HEX_EXT_W-1:0]       value_ext;
   logic [BCD_EXT_W-1:0]       bcd_ext;
   logic [3:0]                 nib;
   logic                       lead;

   assign conv_start = (state_q == IDLE) && bus.load_i && !bus.hex_mode_i;

   seg7_bin2bcd #(.BIN_WIDTH(BIN_WIDTH), .BCD_DIGITS(BCD_DIGITS)) u_bin2bcd (
      .clk     (clk),
      .rst_n   (rst),
      .start_i (conv_start),
      .value_i (bus.value_i),
      .done_o  (conv_done),
      .bcd_o   (bcd)
   );

   // Digit images for the commit; leading zeros scanned from the top digit down.
   always_comb begin
      value_ext = HEX_EXT_W'(value_q);
      bcd_ext   = BCD_EXT_W'(bcd);
      ovf_new   = 1'b0;
      for (int b = DIG_W; b < HEX_EXT_W; b++) if (hex_q) ovf_new = ovf_new | value_ext[b];
      for (int b = DIG_W; b < BCD_EXT_W; b++) if (!hex_q) ovf_new = ovf_new | bcd_ext[b];
      lead     = 1'b1;
      nib      = '0;
      disp_new = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         nib = hex_q ? value_ext[4*i +: 4] : bcd_ext[4*i +: 4];
         if (ovf_new) begin
            disp_new[i] = SEG_DASH;
         end else if (blank_q && lead && (nib == 4'd0) && (i != 0)) begin
            disp_new[i] = SEG_BLANK;
         end else begin
            disp_new[i] = hex_to_seg(nib);
            lead        = 1'b0;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      value_d = value_q;
      hex_d   = hex_q;
      blank_d = blank_q;
      dpcap_d = dpcap_q;
      disp_d  = disp_q;
      dpr_d   = dpr_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.load_i) begin
               value_d = bus.value_i;
               hex_d   = bus.hex_mode_i;
               blank_d = bus.blank_lz_i;
               dpcap_d = bus.dp_i;
               state_d = bus.hex_mode_i ? COMMIT : CONVERT;
            end
         end
         CONVERT: if (conv_done) state_d = COMMIT;
         COMMIT: begin
            disp_d  = disp_new;
            dpr_d   = dpcap_q;
            ovf_d   = ovf_new;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_comb begin
      ref_d = (ref_q == REF_W'(REFRESH_DIV - 1)) ? '0 : ref_q + REF_W'(1);
      idx_d = idx_q;
      if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = disp_q[idx_q];
      dpo_d = ~dpr_q[idx_q];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
         value_q <= '0;
         hex_q   <= 1'b0;
         blank_q <= 1'b0;
         dpcap_q <= '0;
         disp_q  <= {NUM_DIGITS{SEG_BLANK}};
         dpr_q   <= '0;
         ref_q   <= '0;
         idx_q   <= '0;
         an_q    <= '1;
         seg_q   <= SEG_BLANK;
         dpo_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
         value_q <= value_d;
         hex_q   <= hex_d;
         blank_q <= blank_d;
         dpcap_q <= dpcap_d;
         disp_q  <= disp_d;
         dpr_q   <= dpr_d;
         ref_q   <= ref_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dpo_q   <= dpo_d;
      end
   end

   assign bus.busy_o     = busy_q;
   assign bus.overflow_o = ovf_q;
   assign seg_o          = seg_q;
   assign dp_o           = dpo_q;
   assign an_o           = an_q;
endmodule
